mips_main_control_32: RTL and testbench
=======================================

Name: mips_main_control_32

Overview:
- Initiator side of the ALU-control start/finish interface.
- Accepts one 32-bit MIPS instruction per transaction and decodes its opcode into datapath control signals and a 2-bit ALUop.
- Drives alu_start, alu_op and alu_func toward alu_control_32 and waits for finish.
- Returns a bundled control word, including the 4-bit alu_control and all error flags, to the datapath sequencer over a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles alu_start may stay high without alu_finish before the timeout error is raised (>=1).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- instr  input  32  instruction word; opcode=instr[31:26], func=instr[5:0]
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction
- alu_start  output  1  request to the ALU-control unit
- alu_op  output  2  ALUop: 00 mem/addi, 01 branch, 10 R-type
- alu_func  output  6  func field forwarded to the ALU-control unit
- alu_control  input  4  ALU-control result
- alu_finish  input  1  ALU-control unit completed the request
- alu_err_func  input  1  illegal func code reported by the ALU-control unit
- alu_err_op  input  1  illegal ALUop reported by the ALU-control unit
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  output  1 each  datapath controls
- ctrl_alu_control  output  4  captured alu_control
- err_opcode, err_func, err_alu_op, err_timeout  output  1 each  sticky-per-transaction error flags
- out_valid  output  1  control word valid
- out_ready  input  1  consumer accepts the control word

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 except instr_ready, which is 1.
  - Timeout counter is cleared.
  - A reset in any state aborts the transaction and drops alu_start on the next edge.
- FSM states: IDLE, DECODE, REQ, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register instr and go to DECODE.
- DECODE (1 cycle):
  - Register the datapath controls and alu_op from the opcode table below.
  - Legal opcode: go to REQ.
  - Illegal opcode: set err_opcode=1, all controls 0, alu_op=00, and go straight to DONE with no ALU request.
- Opcode table:
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
- REQ:
  - alu_start=1; alu_op and alu_func are held stable for the whole state.
  - On a cycle with alu_finish=1:
    - Capture alu_control into ctrl_alu_control.
    - Capture alu_err_func into err_func and alu_err_op into err_alu_op.
    - Go to DONE; alu_start is 0 from the next cycle.
  - Counter increments on each REQ cycle without finish.
  - When the counter reaches TIMEOUT_CYCLES: set err_timeout=1, ctrl_alu_control=0, go to DONE.
  - If finish arrives on the same cycle as the timeout, finish wins and err_timeout stays 0.
- DONE:
  - out_valid=1; all control outputs are held stable.
  - On out_ready, go to IDLE and clear the error flags and the counter.
  - instr_ready=0 outside IDLE, so there is no overlap between transactions.
- Latency:
  - Accept at cycle N, DECODE at N+1, REQ from N+2.
  - With zero-wait finish, out_valid rises at N+3.
  - Illegal opcode: out_valid at N+2.
- alu_finish outside REQ is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - ALUop constants ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10.
  - FSM state enum.
- One combinational sub-module, mips_opcode_decode: opcode in -> control bits, alu_op and an illegal flag.

Test Plan:
- lw (opcode 100011), ALU model returns alu_control=0010 with finish at the first REQ cycle -> out_valid at N+3; alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, ctrl_alu_control=0010, all errors 0.
- R-type with func=101010 (slt), finish delayed 3 cycles -> alu_start high for exactly 4 cycles; alu_op=10 and alu_func=101010 stable throughout; ctrl_alu_control=0111.
- Opcode 111111 -> alu_start never asserted; err_opcode=1; out_valid at N+2.
- R-type func=111010, ALU model returns alu_err_func=1 -> err_func=1; reg_dst=1.
- ALU never finishes -> err_timeout=1 after 16 REQ cycles and alu_start drops; a finish coinciding with the 16th cycle -> err_timeout=0.
- out_ready held low 5 cycles in DONE -> outputs stable and instr_ready=0; reset asserted mid-REQ -> IDLE with alu_start=0 on the next edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/ALUop constants, control bundle and FSM state type for the MIPS main control.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StReq,
    StDone
  } state_e;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode decoder: datapath controls, ALUop and an illegal-opcode flag.
module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    alu_op_o  = ALUOP_MEM;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        alu_op_o         = ALUOP_R;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        alu_op_o      = ALUOP_BR;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_main_control_32.sv
// MIPS main control: decodes one instruction, requests ALU control, returns a control word.
module mips_main_control_32
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic        alu_start_o,
  output logic [1:0]  alu_op_o,
  output logic [5:0]  alu_func_o,
  input  logic [3:0]  alu_control_i,
  input  logic        alu_finish_i,
  input  logic        alu_err_func_i,
  input  logic        alu_err_op_i,
  output logic        reg_dst_o,
  output logic        alu_src_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic [3:0]  ctrl_alu_control_o,
  output logic        err_opcode_o,
  output logic        err_func_o,
  output logic        err_alu_op_o,
  output logic        err_timeout_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       func_q, func_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic             err_opcode_q, err_opcode_d;
  logic             err_func_q, err_func_d;
  logic             err_alu_op_q, err_alu_op_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t      dec_ctrl;
  logic [1:0] dec_alu_op;
  logic       dec_illegal;
  logic       unused_instr;

  assign unused_instr = ^instr_i[25:6];

  mips_opcode_decode u_decode (
    .opcode_i  (opcode_q),
    .ctrl_o    (dec_ctrl),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    func_d        = func_q;
    ctrl_d        = ctrl_q;
    alu_op_d      = alu_op_q;
    alu_ctl_d     = alu_ctl_q;
    err_opcode_d  = err_opcode_q;
    err_func_d    = err_func_q;
    err_alu_op_d  = err_alu_op_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid_i) begin
          opcode_d = instr_i[31:26];
          func_d   = instr_i[5:0];
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Illegal opcodes decode to all-zero controls and skip the ALU request.
        ctrl_d       = dec_ctrl;
        alu_op_d     = dec_alu_op;
        alu_ctl_d    = '0;
        err_opcode_d = dec_illegal;
        cnt_d        = '0;
        state_d      = dec_illegal ? StDone : StReq;
      end
      StReq: begin
        if (alu_finish_i) begin
          alu_ctl_d    = alu_control_i;
          err_func_d   = alu_err_func_i;
          err_alu_op_d = alu_err_op_i;
          state_d      = StDone;
        end else if (cnt_q == CntLast) begin
          err_timeout_d = 1'b1;
          alu_ctl_d     = '0;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          err_opcode_d  = 1'b0;
          err_func_d    = 1'b0;
          err_alu_op_d  = 1'b0;
          err_timeout_d = 1'b0;
          cnt_d         = '0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      opcode_q      <= '0;
      func_q        <= '0;
      ctrl_q        <= '0;
      alu_op_q      <= '0;
      alu_ctl_q     <= '0;
      err_opcode_q  <= 1'b0;
      err_func_q    <= 1'b0;
      err_alu_op_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      func_q        <= func_d;
      ctrl_q        <= ctrl_d;
      alu_op_q      <= alu_op_d;
      alu_ctl_q     <= alu_ctl_d;
      err_opcode_q  <= err_opcode_d;
      err_func_q    <= err_func_d;
      err_alu_op_q  <= err_alu_op_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign instr_ready_o      = (state_q == StIdle);
  assign alu_start_o        = (state_q == StReq);
  assign out_valid_o        = (state_q == StDone);
  assign alu_op_o           = alu_op_q;
  assign alu_func_o         = func_q;
  assign reg_dst_o          = ctrl_q.reg_dst;
  assign alu_src_o          = ctrl_q.alu_src;
  assign mem_to_reg_o       = ctrl_q.mem_to_reg;
  assign reg_write_o        = ctrl_q.reg_write;
  assign mem_read_o         = ctrl_q.mem_read;
  assign mem_write_o        = ctrl_q.mem_write;
  assign branch_o           = ctrl_q.branch;
  assign ctrl_alu_control_o = alu_ctl_q;
  assign err_opcode_o       = err_opcode_q;
  assign err_func_o         = err_func_q;
  assign err_alu_op_o       = err_alu_op_q;
  assign err_timeout_o      = err_timeout_q;

endmodule

// File: tb/tb_mips_main_control_32.sv
// Directed self-checking bench for mips_main_control_32 with a hand-driven ALU-control model.
module tb_mips_main_control_32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [5:0]  alu_func;
  logic [3:0]  alu_control;
  logic        alu_finish;
  logic        alu_err_func;
  logic        alu_err_op;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [3:0]  ctrl_alu_control;
  logic        err_opcode, err_func, err_alu_op, err_timeout;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
  logic [6:0] ctl;
  logic [3:0] errs;
  assign ctl  = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch};
  assign errs = {err_opcode, err_func, err_alu_op, err_timeout};

  always #5 clk = ~clk;

  mips_main_control_32 #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .instr_i            (instr),
    .instr_valid_i      (instr_valid),
    .instr_ready_o      (instr_ready),
    .alu_start_o        (alu_start),
    .alu_op_o           (alu_op),
    .alu_func_o         (alu_func),
    .alu_control_i      (alu_control),
    .alu_finish_i       (alu_finish),
    .alu_err_func_i     (alu_err_func),
    .alu_err_op_i       (alu_err_op),
    .reg_dst_o          (reg_dst),
    .alu_src_o          (alu_src),
    .mem_to_reg_o       (mem_to_reg),
    .reg_write_o        (reg_write),
    .mem_read_o         (mem_read),
    .mem_write_o        (mem_write),
    .branch_o           (branch),
    .ctrl_alu_control_o (ctrl_alu_control),
    .err_opcode_o       (err_opcode),
    .err_func_o         (err_func),
    .err_alu_op_o       (err_alu_op),
    .err_timeout_o      (err_timeout),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one instruction in IDLE; returns with the DUT in DECODE.
  task automatic send(input logic [31:0] i);
    instr       = i;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, instr_ready, 1);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    instr        = '0;
    instr_valid  = 1'b0;
    alu_control  = '0;
    alu_finish   = 1'b0;
    alu_err_func = 1'b0;
    alu_err_op   = 1'b0;
    out_ready    = 1'b0;
    step();
    step();
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_errs", errs, 0);
    chk("rst_ctrl_alu", ctrl_alu_control, 0);
    chk("rst_alu_op_func", {alu_op, alu_func}, 0);
    reset = 1'b0;
    step();

    // lw with zero-wait finish: out_valid at N+3
    send({6'b100011, 26'h0});
    chk("lw_decode_ready", instr_ready, 0);
    chk("lw_decode_start", alu_start, 0);
    chk("lw_decode_valid", out_valid, 0);
    step();
    chk("lw_req_start", alu_start, 1);
    chk("lw_req_op", alu_op, 2'b00);
    chk("lw_req_valid", out_valid, 0);
    alu_finish  = 1'b1;
    alu_control = 4'b0010;
    step();
    alu_finish  = 1'b0;
    alu_control = 4'b0000;
    chk("lw_done_valid", out_valid, 1);
    chk("lw_done_start", alu_start, 0);
    chk("lw_ctl", ctl, 7'b0111100);
    chk("lw_ctrl_alu", ctrl_alu_control, 4'b0010);
    chk("lw_errs", errs, 0);
    drain("lw");

    // R-type slt, finish delayed 3 cycles: alu_start high for exactly 4 cycles
    send({6'b000000, 20'h0, 6'b101010});
    step();
    for (int k = 0; k < 3; k++) begin
      chk("slt_wait_start", alu_start, 1);
      chk("slt_wait_op_func", {alu_op, alu_func}, {2'b10, 6'b101010});
      step();
    end
    chk("slt_fin_start", alu_start, 1);
    chk("slt_fin_op_func", {alu_op, alu_func}, {2'b10, 6'b101010});
    alu_finish  = 1'b1;
    alu_control = 4'b0111;
    step();
    alu_finish  = 1'b0;
    alu_control = 4'b0000;
    chk("slt_done_start", alu_start, 0);
    chk("slt_done_valid", out_valid, 1);
    chk("slt_ctl", ctl, 7'b1001000);
    chk("slt_ctrl_alu", ctrl_alu_control, 4'b0111);
    chk("slt_errs", errs, 0);
    drain("slt");

    // Illegal opcode: no ALU request, out_valid at N+2, stray finish ignored
    send({6'b111111, 26'h0});
    alu_finish  = 1'b1;
    alu_control = 4'b1111;
    chk("ill_decode_start", alu_start, 0);
    chk("ill_decode_valid", out_valid, 0);
    step();
    chk("ill_done_valid", out_valid, 1);
    chk("ill_done_start", alu_start, 0);
    chk("ill_errs", errs, 4'b1000);
    chk("ill_ctl", ctl, 0);
    chk("ill_alu_op", alu_op, 0);
    step();
    chk("ill_stray_finish", ctrl_alu_control, 0);
    alu_finish  = 1'b0;
    alu_control = 4'b0000;
    drain("ill");

    // R-type with illegal func reported by the ALU-control unit
    send({6'b000000, 20'h0, 6'b111010});
    step();
    alu_finish   = 1'b1;
    alu_err_func = 1'b1;
    step();
    alu_finish   = 1'b0;
    alu_err_func = 1'b0;
    chk("efunc_errs", errs, 4'b0100);
    chk("efunc_reg_dst", reg_dst, 1);
    drain("efunc");

    // beq with ALUop error reported
    send({6'b000100, 26'h0});
    step();
    chk("beq_op", alu_op, 2'b01);
    alu_finish  = 1'b1;
    alu_err_op  = 1'b1;
    alu_control = 4'b0110;
    step();
    alu_finish  = 1'b0;
    alu_err_op  = 1'b0;
    alu_control = 4'b0000;
    chk("beq_errs", errs, 4'b0010);
    chk("beq_ctl", ctl, 7'b0000001);
    chk("beq_ctrl_alu", ctrl_alu_control, 4'b0110);
    drain("beq");

    // sw, ALU never finishes: timeout after 16 REQ cycles
    send({6'b101011, 26'h0});
    step();
    for (int k = 0; k < 16; k++) begin
      chk("to_start_high", alu_start, 1);
      step();
    end
    chk("to_start_drop", alu_start, 0);
    chk("to_valid", out_valid, 1);
    chk("to_errs", errs, 4'b0001);
    chk("to_ctrl_alu", ctrl_alu_control, 0);
    chk("to_ctl", ctl, 7'b0100010);
    drain("to");

    // addi, finish on the 16th REQ cycle wins over timeout
    send({6'b001000, 26'h0});
    step();
    for (int k = 0; k < 15; k++) begin
      chk("race_start_high", alu_start, 1);
      step();
    end
    chk("race_last_start", alu_start, 1);
    alu_finish  = 1'b1;
    alu_control = 4'b0010;
    step();
    alu_finish  = 1'b0;
    alu_control = 4'b0000;
    chk("race_valid", out_valid, 1);
    chk("race_errs", errs, 0);
    chk("race_ctrl_alu", ctrl_alu_control, 4'b0010);

    // Back-pressure: DONE held 5 cycles with a new instruction offered
    instr       = {6'b100011, 26'h0};
    instr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", instr_ready, 0);
      chk("bp_ctl", ctl, 7'b0101000);
      chk("bp_ctrl_alu", ctrl_alu_control, 4'b0010);
    end
    instr_valid = 1'b0;
    drain("bp");

    // Reset mid-REQ aborts the transaction
    send({6'b100011, 26'h0});
    step();
    step();
    chk("mrst_req_start", alu_start, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_start", alu_start, 0);
    chk("mrst_ready", instr_ready, 1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ctl", ctl, 0);
    step();
    chk("mrst_idle_start", alu_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
